// File: rtl/sram_port_master.sv
// ----------------------------------------------------------------------------
// sram_port_master
//
// Purpose:
//   Initiator for a single-port SRAM. A client sends one request at a time
//   over a valid/ready handshake. The master drives the SRAM pins, waits for
//   the SRAM completion pulse, captures read data and returns a response. If
//   the SRAM does not answer in time, the response carries an error flag.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset_n    synchronous, active-low reset
//   req_valid  client request present
//   req_ready  master can accept a request (high only in IDLE)
//   req_write  1 = write, 0 = read
//   req_addr   request address
//   req_wdata  write data
//   rsp_valid  response available (high only in RESP)
//   rsp_ready  client consumes the response
//   rsp_rdata  read data (0 for writes and on timeout)
//   rsp_error  1 = access timed out
//   mem_re     SRAM read enable
//   mem_we     SRAM write enable
//   mem_addr   SRAM address
//   mem_data   shared data bus, driven by the master only while mem_we = 1
//   mem_resp   SRAM completion, arrives one cycle after re/we is seen
// ----------------------------------------------------------------------------
module sram_port_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_resp
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  mem_re_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_error_q;

    // Whole access sequencer. Every SRAM-side and response-side output is a
    // register updated here, so the pins never glitch. The read/write
    // direction lives in the state itself, so no separate write flag is kept.
    // mem_resp is only looked at in READ/WRITE; the SRAM produces one
    // leftover pulse after re/we drop, which lands in RESP and is ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wdata_q     <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr_q <= req_addr;
                        wdata_q    <= req_wdata;
                        count_q    <= '0;
                        if (req_write) begin
                            mem_we_q <= 1'b1;
                            state_q  <= WRITE;
                        end else begin
                            mem_re_q <= 1'b1;
                            state_q  <= READ;
                        end
                    end
                end
                READ, WRITE: begin
                    // A completion in the same cycle as the timeout wins.
                    if (mem_resp || (count_q == CNT_LAST)) begin
                        mem_re_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= !mem_resp;
                        if (mem_resp && (state_q == READ)) begin
                            rsp_rdata_q <= mem_data;
                        end else begin
                            rsp_rdata_q <= '0;
                        end
                        state_q <= RESP;
                    end else begin
                        count_q <= count_q + CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;

    // The bus is driven only during a write, so it can never fight the SRAM's
    // read data.
    assign mem_data = mem_we_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_port_master.sv
// ----------------------------------------------------------------------------
// tb_sram_port_master
//
// Purpose:
//   Self-checking bench for sram_port_master. A small behavioural SRAM sits on
//   the memory side. Expected responses are queued when a request is issued,
//   then popped and compared when the master presents its response.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_sram_port_master;

    localparam int DW  = 8;
    localparam int AW  = 14;
    localparam int TMO = 15;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          error;
    } rsp_t;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_resp;

    int   testsRun;
    int   testsFailed;
    rsp_t expQ[$];
    logic [DW-1:0] refMem [0:(1<<AW)-1];

    // Behavioural SRAM: completion one cycle after re/we, read data put on
    // the bus only while re is still high and a completion is showing.
    logic [DW-1:0] sramMem [0:(1<<AW)-1];
    logic          sramRespQ;
    logic [DW-1:0] sramRdQ;
    logic          sramRespEn;
    logic          extraResp;
    logic          monEn;

    always @(posedge clk) begin
        sramRespQ <= (mem_re | mem_we) & sramRespEn;
        if (mem_we) sramMem[mem_addr] <= mem_data;
        if (mem_re) sramRdQ <= sramMem[mem_addr];
    end

    assign mem_resp = sramRespQ | extraResp;
    assign mem_data = (mem_re && sramRespQ) ? sramRdQ : {DW{1'bz}};

    sram_port_master #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_resp  (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus rule watch: read and write enables must never be high together.
    always @(negedge clk) begin
        if (monEn && (mem_re || mem_we)) begin
            testsRun++;
            if (mem_re && mem_we) begin
                testsFailed++;
                $display("[TB] FAIL re_we_overlap: re=%b we=%b required not both 1", mem_re, mem_we);
            end
        end
    end

    // Issue one access from a negedge, follow it to its response and retire
    // the handshake. Returns at the negedge after the master is back in IDLE.
    task automatic doAccess(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input int expCycles,
                            input int holdCycles, input string name);
        rsp_t exp;
        rsp_t got;
        int   cycles;
        logic seen;
        logic [DW-1:0] heldData;
        logic          heldErr;
        exp.rdata = wr ? '0 : (sramRespEn ? refMem[addr] : '0);
        exp.error = !sramRespEn;
        expQ.push_back(exp);
        if (wr && sramRespEn) refMem[addr] = wd;

        testsRun++;
        if (req_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s_req_ready: got %b required 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;

        testsRun++;
        if (mem_addr !== addr || (wr && mem_data !== wd)) begin
            testsFailed++;
            $display("[TB] FAIL %s_pins: addr=%h data=%h required addr=%h data=%h", name, mem_addr, mem_data, addr, wd);
        end

        cycles = 0;
        seen   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (wr ? mem_we : mem_re) cycles++;
            @(negedge clk);
        end

        got = expQ.pop_front();
        testsRun++;
        if (!seen) begin
            testsFailed++;
            $display("[TB] FAIL %s_no_response: rsp_valid never rose within 60 cycles", name);
        end else begin
            if (cycles != expCycles || rsp_rdata !== got.rdata || rsp_error !== got.error) begin
                testsFailed++;
                $display("[TB] FAIL %s_response: cycles=%0d rdata=%h err=%b required cycles=%0d rdata=%h err=%b",
                         name, cycles, rsp_rdata, rsp_error, expCycles, got.rdata, got.error);
            end
        end

        // Stall the client and try to sneak in a new request meanwhile.
        heldData = rsp_rdata;
        heldErr  = rsp_error;
        for (int i = 0; i < holdCycles; i++) begin
            req_valid = 1'b1;
            req_write = i[0];
            req_addr  = AW'(i + 100);
            @(negedge clk);
            testsRun++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== heldData || rsp_error !== heldErr ||
                req_ready !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL %s_hold%0d: valid=%b rdata=%h err=%b rdy=%b re=%b we=%b required 1 %h %b 0 0 0",
                         name, i, rsp_valid, rsp_rdata, rsp_error, req_ready, mem_re, mem_we, heldData, heldErr);
            end
        end
        req_valid = 1'b0;

        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        testsRun++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s_retire: rsp_valid=%b req_ready=%b required 0 1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || rsp_valid !== 1'b0 ||
            rsp_rdata !== '0 || rsp_error !== 1'b0 || req_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: re=%b we=%b addr=%h valid=%b rdata=%h err=%b rdy=%b required 0 0 0 0 0 0 1",
                     mem_re, mem_we, mem_addr, rsp_valid, rsp_rdata, rsp_error, req_ready);
        end
        reset_n = 1'b1;
        monEn   = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        doAccess(1'b1, 14'h0005, 8'hA5, 2, 0, "write_a5");
    endtask

    task automatic test_read();
        doAccess(1'b0, 14'h0005, 8'h00, 2, 0, "read_a5");
    endtask

    task automatic test_timeout();
        sramRespEn = 1'b0;
        doAccess(1'b0, 14'h0005, 8'h00, TMO, 0, "timeout");
        sramRespEn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hold();
        doAccess(1'b1, 14'h0123, 8'h5C, 2, 0, "hold_wr");
        doAccess(1'b0, 14'h0123, 8'h00, 2, 5, "hold_rd");
    endtask

    task automatic test_reset_mid_read();
        sramRespEn = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 14'h0005;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++;
        if (mem_re !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midrd_active: mem_re=%b required 1", mem_re);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midrd_reset: re=%b we=%b valid=%b rdy=%b required 0 0 0 1",
                     mem_re, mem_we, rsp_valid, req_ready);
        end
        reset_n    = 1'b1;
        sramRespEn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        doAccess(1'b1, 14'h0010, 8'h3C, 2, 0, "b2b_w1");
        doAccess(1'b0, 14'h0010, 8'h00, 2, 0, "b2b_r");
        doAccess(1'b1, 14'h0011, 8'h77, 2, 0, "b2b_w2");
        doAccess(1'b0, 14'h0011, 8'h00, 2, 0, "b2b_r2");
        // A spurious completion in IDLE must not start or finish anything.
        extraResp = 1'b1;
        @(posedge clk);
        @(negedge clk);
        extraResp = 1'b0;
        testsRun++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_stale_resp: valid=%b rdy=%b re=%b we=%b required 0 1 0 0",
                     rsp_valid, req_ready, mem_re, mem_we);
        end
        doAccess(1'b0, 14'h0005, 8'h00, 2, 0, "final_rd");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        monEn       = 1'b0;
        sramRespEn  = 1'b1;
        extraResp   = 1'b0;
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        rsp_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_hold();
        test_reset_mid_read();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
